// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing and a small receive FIFO carrying per-entry error flags.
// Define UART_RX_SYNC_EN to insert a two-flop input synchronizer ahead of the receiver.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 10000,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx_serial,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic                        parity_err,
   output logic                        frame_err,
   output logic                        overrun,
   input  logic                        err_clr,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned EW    = DATA_BITS + 2;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2);
   localparam logic [AW:0]      CNT_FULL  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;

   logic w_rx;
   logic w_armed_set;

`ifdef UART_RX_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '1;
      else     r_sync <= {r_sync[0], rx_serial};
   end

   assign w_rx = r_sync[1];
   // Synchronizer resets high; only arm once the raw line is also seen high.
   assign w_armed_set = r_sync[1] & r_sync[0] & rx_serial;
`else
   assign w_rx        = rx_serial;
   assign w_armed_set = rx_serial;
`endif

   // ---------------------------------------------------------------- receiver
   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic               r_stop_idx, w_stop_idx_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic               r_perr, w_perr_nxt;
   logic               r_ferr, w_ferr_nxt;
   logic               r_armed;
   logic               w_push;
   logic               r_push;
   logic [EW-1:0]      r_push_ent;
   logic               w_par_x;

   assign w_par_x = (^r_shift) ^ w_rx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt + 1'b1;
      w_idx_nxt      = r_idx;
      w_stop_idx_nxt = r_stop_idx;
      w_shift_nxt    = r_shift;
      w_perr_nxt     = r_perr;
      w_ferr_nxt     = r_ferr;
      w_push         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt      = '0;
            w_idx_nxt      = '0;
            w_stop_idx_nxt = 1'b0;
            w_perr_nxt     = 1'b0;
            w_ferr_nxt     = 1'b0;
            if (r_armed && !w_rx) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (r_cnt == HALF_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
               if (r_idx == DATA_LAST)
                  w_state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
               else
                  w_idx_nxt = r_idx + 1'b1;
            end
         end
         ST_PARITY: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_nxt   = '0;
               w_perr_nxt  = (PARITY == 1) ? ~w_par_x : w_par_x;
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_nxt  = '0;
               w_ferr_nxt = r_ferr | ~w_rx;
               if (r_stop_idx == STOP_LAST) begin
                  w_push      = 1'b1;
                  w_state_nxt = w_ferr_nxt ? ST_BREAK : ST_IDLE;
               end else begin
                  w_stop_idx_nxt = 1'b1;
               end
            end
         end
         ST_BREAK: begin
            w_cnt_nxt = '0;
            if (w_rx) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Push is registered so the FIFO sees the frame one cycle after its last stop sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_armed    <= 1'b0;
         r_push     <= 1'b0;
         r_push_ent <= '0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_stop_idx <= w_stop_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_perr     <= w_perr_nxt;
         r_ferr     <= w_ferr_nxt;
         r_push     <= w_push;
         if (w_armed_set) r_armed <= 1'b1;
         if (w_push) r_push_ent <= {w_perr_nxt, w_ferr_nxt, w_shift_nxt};
      end
   end

   // -------------------------------------------------------------------- FIFO
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overrun;
   logic          w_full, w_pop, w_wr, w_ovf;
   logic [EW-1:0] w_head;

   assign w_full = (r_count == CNT_FULL);
   assign w_pop  = rx_valid & rx_ready;
   assign w_wr   = r_push & (~w_full | w_pop);
   assign w_ovf  = r_push & w_full & ~w_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_ovf)        r_overrun <= 1'b1;
         else if (err_clr) r_overrun <= 1'b0;
      end
   end

   // When full, a simultaneous pop frees the slot the write pointer already addresses.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_push_ent;
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign rx_valid   = (r_count != '0);
   assign rx_data    = rx_valid ? w_head[DATA_BITS-1:0] : '0;
   assign frame_err  = rx_valid & w_head[DATA_BITS];
   assign parity_err = rx_valid & w_head[DATA_BITS+1];
   assign overrun    = r_overrun;
   assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance at 10 clocks per bit.
module tb_uart_rx_fifo;

   localparam int CPB = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rx_n, rx_e, rdy_n, rdy_e, clr_n, clr_e;
   logic [7:0] data_n, data_e;
   logic       val_n, val_e, perr_n, perr_e, ferr_n, ferr_e, ovr_n, ovr_e;
   logic [2:0] cnt_n, cnt_e;

   int n_tests = 0;
   int n_fail  = 0;

   logic [9:0] q_n[$];
   logic [9:0] q_e[$];
   int         vcyc_n = 0;

   uart_rx_fifo #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) dut_n (
      .clk(clk), .rst(rst), .rx_serial(rx_n), .rx_data(data_n), .rx_valid(val_n),
      .rx_ready(rdy_n), .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n),
      .err_clr(clr_n), .fifo_count(cnt_n)
   );

   uart_rx_fifo #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) dut_e (
      .clk(clk), .rst(rst), .rx_serial(rx_e), .rx_data(data_e), .rx_valid(val_e),
      .rx_ready(rdy_e), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e),
      .err_clr(clr_e), .fifo_count(cnt_e)
   );

   // Popped entries {parity_err, frame_err, data}, sampled mid-cycle.
   always @(negedge clk) begin
      if (val_n) vcyc_n++;
      if (val_n && rdy_n) q_n.push_back({perr_n, ferr_n, data_n});
      if (val_e && rdy_e) q_e.push_back({perr_e, ferr_e, data_e});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) rx_e = v;
      else     rx_n = v;
   endtask

   // par < 0 means no parity bit; the stop level is left on the line afterwards.
   task automatic send_frame(input bit sel, input logic [7:0] d, input int par, input logic stop);
      set_line(sel, 1'b0);
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         set_line(sel, d[i]);
         tick(CPB);
      end
      if (par >= 0) begin
         set_line(sel, par[0]);
         tick(CPB);
      end
      set_line(sel, stop);
      tick(CPB);
   endtask

   function automatic logic [9:0] ent_n(input int idx);
      return (idx < q_n.size()) ? q_n[idx] : 10'h3FF;
   endfunction

   function automatic logic [9:0] ent_e(input int idx);
      return (idx < q_e.size()) ? q_e[idx] : 10'h3FF;
   endfunction

   initial begin
      int         base;
      int         v0;
      logic [7:0] b;
      logic [7:0] exp_pop [4];

      rst = 1'b1; rx_n = 1'b1; rx_e = 1'b1;
      rdy_n = 1'b0; rdy_e = 1'b0; clr_n = 1'b0; clr_e = 1'b0;
      tick(3);
      check("rst_valid",  {31'd0, val_n},  32'd0);
      check("rst_data",   {24'd0, data_n}, 32'd0);
      check("rst_perr",   {31'd0, perr_n}, 32'd0);
      check("rst_ferr",   {31'd0, ferr_n}, 32'd0);
      check("rst_ovr",    {31'd0, ovr_n},  32'd0);
      check("rst_count",  {29'd0, cnt_n},  32'd0);
      rst = 1'b0;
      tick(5);

      // 8N1 0x41, consumer always ready
      base = q_n.size(); v0 = vcyc_n; rdy_n = 1'b1;
      send_frame(1'b0, 8'h41, -1, 1'b1);
      tick(5);
      check("n41_entries", q_n.size() - base, 1);
      check("n41_data",    {24'd0, ent_n(base)[7:0]}, 32'h41);
      check("n41_perr",    {31'd0, ent_n(base)[9]},   32'd0);
      check("n41_ferr",    {31'd0, ent_n(base)[8]},   32'd0);
      check("n41_vcycles", vcyc_n - v0, 1);
      check("n41_count",   {29'd0, cnt_n}, 32'd0);

      // 8E1: 0x41 with wrong parity 1, then 0x03 with correct parity 0
      base = q_e.size(); rdy_e = 1'b1;
      send_frame(1'b1, 8'h41, 1, 1'b1);
      tick(5);
      send_frame(1'b1, 8'h03, 0, 1'b1);
      tick(5);
      check("e_entries", q_e.size() - base, 2);
      check("e41_data",  {24'd0, ent_e(base)[7:0]},   32'h41);
      check("e41_perr",  {31'd0, ent_e(base)[9]},     32'd1);
      check("e41_ferr",  {31'd0, ent_e(base)[8]},     32'd0);
      check("e03_data",  {24'd0, ent_e(base+1)[7:0]}, 32'h03);
      check("e03_perr",  {31'd0, ent_e(base+1)[9]},   32'd0);

      // 0xA5 with low stop bit, line held low 30 more cycles
      base = q_n.size();
      send_frame(1'b0, 8'hA5, -1, 1'b0);
      tick(30);
      check("brk_entries_low", q_n.size() - base, 1);
      check("brk_data",  {24'd0, ent_n(base)[7:0]}, 32'hA5);
      check("brk_ferr",  {31'd0, ent_n(base)[8]},   32'd1);
      check("brk_perr",  {31'd0, ent_n(base)[9]},   32'd0);
      set_line(1'b0, 1'b1);
      tick(40);
      check("brk_entries_high", q_n.size() - base, 1);
      check("brk_count", {29'd0, cnt_n}, 32'd0);

      // 3-cycle glitch on idle line
      base = q_n.size(); v0 = vcyc_n;
      set_line(1'b0, 1'b0);
      tick(3);
      set_line(1'b0, 1'b1);
      tick(30);
      check("glitch_entries", q_n.size() - base, 0);
      check("glitch_vcycles", vcyc_n - v0, 0);
      check("glitch_valid",   {31'd0, val_n}, 32'd0);
      check("glitch_count",   {29'd0, cnt_n}, 32'd0);

      // Overrun: five frames into a depth-4 FIFO with no consumer
      rdy_n = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         b = 8'(i * 8'h11);
         send_frame(1'b0, b, -1, 1'b1);
         tick(3);
      end
      check("ovf_count", {29'd0, cnt_n},  32'd4);
      check("ovf_flag",  {31'd0, ovr_n},  32'd1);
      check("ovf_valid", {31'd0, val_n},  32'd1);
      check("ovf_head",  {24'd0, data_n}, 32'h11);
      base = q_n.size();
      for (int i = 0; i < 4; i++) begin
         rdy_n = 1'b1;
         tick(1);
         rdy_n = 1'b0;
         tick(1);
      end
      exp_pop[0] = 8'h11; exp_pop[1] = 8'h22; exp_pop[2] = 8'h33; exp_pop[3] = 8'h44;
      for (int i = 0; i < 4; i++)
         check($sformatf("ovf_pop%0d", i), {24'd0, ent_n(base+i)[7:0]}, {24'd0, exp_pop[i]});
      check("ovf_drained", {29'd0, cnt_n}, 32'd0);
      check("ovf_sticky",  {31'd0, ovr_n}, 32'd1);
      clr_n = 1'b1;
      tick(1);
      clr_n = 1'b0;
      check("ovf_cleared", {31'd0, ovr_n}, 32'd0);

      // Reset during data bit 3 of 0x5A, then 0xC3
      rdy_n = 1'b1; base = q_n.size(); b = 8'h5A;
      set_line(1'b0, 1'b0);
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         set_line(1'b0, b[i]);
         tick(CPB);
      end
      set_line(1'b0, b[3]);
      tick(5);
      rst = 1'b1;
      tick(2);
      check("mid_rst_count", {29'd0, cnt_n}, 32'd0);
      check("mid_rst_valid", {31'd0, val_n}, 32'd0);
      rst = 1'b0;
      set_line(1'b0, 1'b1);
      tick(40);
      send_frame(1'b0, 8'hC3, -1, 1'b1);
      tick(5);
      check("rst_c3_entries", q_n.size() - base, 1);
      check("rst_c3_data",    {24'd0, ent_n(base)[7:0]}, 32'hC3);
      check("rst_c3_ferr",    {31'd0, ent_n(base)[8]},   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
